// File: rtl/sc_regshift_pkg.sv
// Shared constants for the multi-cycle shift register: FSM encoding and shift directions.
package sc_regshift_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/sc_regshift_ctrl.sv
// Sequencer for sc_regshift: IDLE/SHIFT/DONE FSM plus the shift-amount down-counter.
module sc_regshift_ctrl
    import sc_regshift_pkg::*;
#(
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   load,
    input  logic [SHAMT_WIDTH-1:0] amount,
    output logic                   startAccept,
    output logic                   shiftEn,
    output logic                   busy,
    output logic                   done
);

    logic [1:0]             state;
    logic [1:0]             stateNext;
    logic [SHAMT_WIDTH-1:0] count;

    // Load takes priority over Start in IDLE.
    assign startAccept = (state == IDLE) && start && !load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            if (startAccept)
                count <= amount;
            else if (state == SHIFT)
                count <= count - 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (startAccept)
                    stateNext = (amount != '0) ? SHIFT : DONE;
            end
            // count==1 marks the final shift, so the counter stops at 0 and never wraps.
            SHIFT: begin
                if (count == {{(SHAMT_WIDTH-1){1'b0}}, 1'b1})
                    stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        shiftEn = (state == SHIFT);
        busy    = (state != IDLE);
        done    = (state == DONE);
    end

endmodule

// File: rtl/sc_regshift.sv
// Multi-cycle shift register: loads a bus word, then shifts it one bit per clock
// left, logical right or arithmetic right under control of sc_regshift_ctrl.
module sc_regshift
    import sc_regshift_pkg::*;
#(
    parameter int                     DATAWIDTH_BUS      = 32,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGSHIFT_INIT = '0,
    parameter int                     SHAMT_WIDTH        = 5
) (
    input  logic                     SC_RegSHIFT_CLOCK_50,
    input  logic                     SC_RegSHIFT_Reset_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegSHIFT_DataBUS_In,
    input  logic                     SC_RegSHIFT_Load_InHigh,
    input  logic                     SC_RegSHIFT_Start_InHigh,
    input  logic                     SC_RegSHIFT_Dir_In,
    input  logic                     SC_RegSHIFT_Arith_In,
    input  logic [SHAMT_WIDTH-1:0]   SC_RegSHIFT_Amount_In,
    output logic [DATAWIDTH_BUS-1:0] SC_RegSHIFT_DataBUS_Out,
    output logic                     SC_RegSHIFT_Busy_Out,
    output logic                     SC_RegSHIFT_Done_Out,
    output logic                     SC_RegSHIFT_Zero_Out
);

    logic [DATAWIDTH_BUS-1:0] dataReg;
    logic [DATAWIDTH_BUS-1:0] shiftedData;
    logic                     dirLatched;
    logic                     arithLatched;
    logic                     fillBit;
    logic                     startAccept;
    logic                     shiftEn;
    logic                     busy;

    sc_regshift_ctrl #(
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_ctrl (
        .clk         (SC_RegSHIFT_CLOCK_50),
        .reset       (SC_RegSHIFT_Reset_InHigh),
        .start       (SC_RegSHIFT_Start_InHigh),
        .load        (SC_RegSHIFT_Load_InHigh),
        .amount      (SC_RegSHIFT_Amount_In),
        .startAccept (startAccept),
        .shiftEn     (shiftEn),
        .busy        (busy),
        .done        (SC_RegSHIFT_Done_Out)
    );

    assign fillBit     = arithLatched & dataReg[DATAWIDTH_BUS-1];
    assign shiftedData = (dirLatched == DIR_LEFT)
                       ? {dataReg[DATAWIDTH_BUS-2:0], 1'b0}
                       : {fillBit, dataReg[DATAWIDTH_BUS-1:1]};

    always_ff @(posedge SC_RegSHIFT_CLOCK_50) begin
        if (SC_RegSHIFT_Reset_InHigh) begin
            dataReg      <= DATA_REGSHIFT_INIT;
            dirLatched   <= DIR_LEFT;
            arithLatched <= 1'b0;
        end else begin
            // Load is honoured only while idle; mid-operation strobes are dropped.
            if (SC_RegSHIFT_Load_InHigh && !busy)
                dataReg <= SC_RegSHIFT_DataBUS_In;
            else if (shiftEn)
                dataReg <= shiftedData;
            if (startAccept) begin
                dirLatched   <= SC_RegSHIFT_Dir_In;
                arithLatched <= SC_RegSHIFT_Arith_In;
            end
        end
    end

    assign SC_RegSHIFT_DataBUS_Out = dataReg;
    assign SC_RegSHIFT_Busy_Out    = busy;
    assign SC_RegSHIFT_Zero_Out    = (dataReg == '0);

endmodule
